// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - four-master fixed-priority RIB bus arbiter with grant lock, timeout and pipeline hold
module rib_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] addr2_i,
  input  logic [31:0] addr3_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  input  logic [31:0] wdata2_i,
  input  logic [31:0] wdata3_i,
  output logic [3:0]  gnt_o,
  output logic [3:0]  ack_o,
  output logic [31:0] rd_data_o,
  output logic        err_o,
  output logic [2:0]  hold_flag_o,
  output logic        slv_req_o,
  output logic [31:0] slv_addr_o,
  output logic        slv_we_o,
  output logic [31:0] slv_wdata_o,
  input  logic        slv_ack_i,
  input  logic [31:0] slv_rdata_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Last BUSY cycle count before a silent slave is forced to an error completion.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // Hold encodings shared with the pipeline hold-flag bus.
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  state_e      state_q, state_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [3:0]  gnt_q, gnt_d;

  logic [1:0]  pri_idx;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_req;
  logic        sel_we;

  // Fixed priority: core data read beats fetch beats debug beats DMA.
  always_comb begin
    pri_idx = 2'd3;
    if (req_i[0]) begin
      pri_idx = 2'd0;
    end else if (req_i[1]) begin
      pri_idx = 2'd1;
    end else if (req_i[2]) begin
      pri_idx = 2'd2;
    end
  end

  // Route the granted master's address, data and controls toward the slave.
  always_comb begin
    sel_addr  = addr0_i;
    sel_wdata = wdata0_i;
    case (gnt_idx_q)
      2'd1: begin
        sel_addr  = addr1_i;
        sel_wdata = wdata1_i;
      end
      2'd2: begin
        sel_addr  = addr2_i;
        sel_wdata = wdata2_i;
      end
      2'd3: begin
        sel_addr  = addr3_i;
        sel_wdata = wdata3_i;
      end
      default: begin
        sel_addr  = addr0_i;
        sel_wdata = wdata0_i;
      end
    endcase
    sel_req = req_i[gnt_idx_q];
    sel_we  = we_i[gnt_idx_q];
  end

  // State, grant index, timeout counter and registered grant vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_idx_q <= 2'd0;
      tmo_cnt_q <= 8'd0;
      gnt_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      tmo_cnt_q <= tmo_cnt_d;
      gnt_q     <= gnt_d;
    end
  end

  // Next-state logic plus the combinational slave and completion outputs.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    gnt_d       = gnt_q;
    ack_o       = 4'b0000;
    rd_data_o   = 32'd0;
    err_o       = 1'b0;
    slv_req_o   = 1'b0;
    slv_addr_o  = 32'd0;
    slv_we_o    = 1'b0;
    slv_wdata_o = 32'd0;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req_i) begin
          gnt_idx_d = pri_idx;
          gnt_d     = 4'b0001 << pri_idx;
          tmo_cnt_d = 8'd0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        slv_req_o   = sel_req;
        slv_addr_o  = sel_addr;
        slv_we_o    = sel_we;
        slv_wdata_o = sel_wdata;
        // Slave ack beats both withdrawal and timeout in the same cycle.
        if (slv_ack_i) begin
          ack_o     = 4'b0001 << gnt_idx_q;
          rd_data_o = slv_rdata_i;
          gnt_d     = 4'b0000;
          state_d   = IDLE;
        end else if (!sel_req) begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          ack_o   = 4'b0001 << gnt_idx_q;
          err_o   = 1'b1;
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // Stall the pipeline while a core master is still waiting for completion.
  always_comb begin
    hold_flag_o = HOLD_NONE;
    if (req_i[0] && !ack_o[0]) begin
      hold_flag_o = HOLD_ID;
    end else if (req_i[1] && !ack_o[1]) begin
      hold_flag_o = HOLD_PC;
    end
  end

  assign gnt_o = gnt_q;

endmodule
